// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive-side capture path.
//   uart_err_t  : per-frame error tags {break_e, stop_e, parity_e}
//   cap_state_t : one-hot state encoding of the rx_done capture FSM
//   sat_inc     : saturating increment for counters up to 32 bits wide
package uart_pkg;

  typedef struct packed {
    logic break_e;
    logic stop_e;
    logic parity_e;
  } uart_err_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b01,
    WAIT_LOW = 2'b10
  } cap_state_t;

  // Callers zero-extend their counter to 32 bits and truncate the result
  // back; w is the real counter width, so the ceiling is 2**w - 1.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/uart_tag_fifo.sv
// Generic first-word-fall-through FIFO.
//   clk, rst        : clock, asynchronous active-high reset
//   clr             : synchronous flush, wins over push/pop
//   push, wr_word   : write request and word; a push while full is only
//                     taken when a pop happens in the same cycle
//   pop             : pop request; ignored while empty
//   rd_word         : head entry (zero while empty)
//   full, empty     : occupancy flags
//   level           : current number of stored entries
module uart_tag_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_word,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_word,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  import uart_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             wr_en, rd_en;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

  // A pop frees the head slot this cycle, so a full FIFO can still accept.
  assign rd_en = pop & ~empty & ~clr;
  assign wr_en = push & (~full | rd_en) & ~clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({wr_en, rd_en})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries data only; it needs no reset because the head is
  // masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_word;
  end

  assign rd_word = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_rx_frame_buffer.sv
// Receive-side capture buffer between uart_receiver and the bus.
// Synchronises the level-type rx_done, captures one tagged frame per
// assertion into an FWFT FIFO and keeps overflow/error statistics.
//   clk, reset      : system clock, asynchronous active-high reset
//   rx_done         : frame-ready level from the receiver (async domain)
//   rx_data, parity_error, stop_error, break_error : frame and tags,
//                     stable while rx_done is high
//   clear           : synchronous flush of FIFO, counters, sticky flags
//   rd_ready        : consumer pop strobe (qualified by rd_valid)
//   rd_valid, rd_data, rd_err : head entry, rd_err = {break, stop, parity}
//   level, full     : occupancy
//   overflow        : sticky frame-dropped flag
//   drop_count, err_count : saturating statistics
//   rx_timeout      : only with UART_RX_TIMEOUT_EN defined; high after
//                     TIMEOUT_CYCLES idle cycles with data pending
module uart_rx_frame_buffer #(
  parameter int          DATA_SIZE      = 8,
  parameter int          DEPTH          = 16,
  parameter int          SYNC_STAGES    = 2,
  parameter int          CNT_WIDTH      = 8,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_done,
  input  logic [DATA_SIZE-1:0]       rx_data,
  input  logic                       parity_error,
  input  logic                       stop_error,
  input  logic                       break_error,
  input  logic                       clear,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [DATA_SIZE-1:0]       rd_data,
  output logic [2:0]                 rd_err,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       overflow,
  output logic [CNT_WIDTH-1:0]       drop_count,
  output logic [CNT_WIDTH-1:0]       err_count
`ifdef UART_RX_TIMEOUT_EN
  ,
  output logic                       rx_timeout
`endif
);
  import uart_pkg::*;

  localparam int WORD_W = DATA_SIZE + 3;
  localparam int LVL_W  = $clog2(DEPTH+1);

  // ---- rx_done synchroniser ----
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   done_s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx_done};
  assign done_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  // ---- capture FSM ----
  // One push per rx_done assertion. The frame is latched together with the
  // push strobe; rx_data and tags are still stable because rx_done is held
  // for at least SYNC_STAGES+2 cycles. clear leaves the state alone so a
  // frame still asserted is not captured twice.
  uart_err_t             in_err;
  cap_state_t            state_q;
  logic                  push_q;
  logic [WORD_W-1:0]     frame_q;

  assign in_err = {break_error, stop_error, parity_error};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      push_q  <= 1'b0;
      frame_q <= '0;
    end else begin
      push_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (done_s) begin
            push_q  <= 1'b1;
            frame_q <= {in_err, rx_data};
            state_q <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!done_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---- FIFO and push/pop arbitration ----
  logic [WORD_W-1:0] rd_word;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic              pop, accept, drop, tag_any;
  uart_err_t         head_err;

  assign pop     = ~fifo_empty & rd_ready;
  assign accept  = push_q & (~fifo_full | pop);
  assign drop    = push_q & fifo_full & ~pop;
  assign tag_any = |frame_q[WORD_W-1:DATA_SIZE];

  uart_tag_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .clr     (clear),
    .push    (push_q),
    .wr_word (frame_q),
    .pop     (pop),
    .rd_word (rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign head_err = rd_word[WORD_W-1:DATA_SIZE];
  assign rd_valid = ~fifo_empty;
  assign rd_data  = rd_word[DATA_SIZE-1:0];
  assign rd_err   = {head_err.break_e, head_err.stop_e, head_err.parity_e};
  assign level    = fifo_level;
  assign full     = fifo_full;

  // ---- statistics ----
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [CNT_WIDTH-1:0] err_q, err_d;

  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    err_d      = err_q;
    if (clear) begin
      overflow_d = 1'b0;
      drop_d     = '0;
      err_d      = '0;
    end else begin
      if (drop) begin
        overflow_d = 1'b1;
        drop_d     = CNT_WIDTH'(sat_inc(32'(drop_q), CNT_WIDTH));
      end
      if (accept && tag_any) begin
        err_d = CNT_WIDTH'(sat_inc(32'(err_q), CNT_WIDTH));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
      err_q      <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign err_count  = err_q;

`ifdef UART_RX_TIMEOUT_EN
  // ---- idle timeout ----
  // Any push strobe, pop or clear restarts the count; it only advances while
  // data is pending and parks at TIMEOUT_CYCLES.
  logic [15:0] idle_q, idle_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    idle_d    = idle_q;
    timeout_d = timeout_q;
    if (push_q || pop || clear) begin
      idle_d    = '0;
      timeout_d = 1'b0;
    end else if (!fifo_empty) begin
      if (idle_q != TIMEOUT_CYCLES) idle_d = idle_q + 16'd1;
      if (idle_d == TIMEOUT_CYCLES) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign rx_timeout = timeout_q;
`else
  logic [15:0] timeout_cfg_unused;
  assign timeout_cfg_unused = TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_uart_rx_frame_buffer.sv
module tb_uart_rx_frame_buffer;

  localparam int DATA_SIZE = 8;
  localparam int DEPTH     = 4;
  localparam int LVL_W     = $clog2(DEPTH+1);
  localparam int CNT_WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 rx_done = 1'b0;
  logic [DATA_SIZE-1:0] rx_data = '0;
  logic                 parity_error = 1'b0;
  logic                 stop_error = 1'b0;
  logic                 break_error = 1'b0;
  logic                 clear = 1'b0;
  logic                 rd_ready = 1'b0;
  logic                 rd_valid;
  logic [DATA_SIZE-1:0] rd_data;
  logic [2:0]           rd_err;
  logic [LVL_W-1:0]     level;
  logic                 full;
  logic                 overflow;
  logic [CNT_WIDTH-1:0] drop_count;
  logic [CNT_WIDTH-1:0] err_count;
`ifdef UART_RX_TIMEOUT_EN
  logic                 rx_timeout;
`endif

  int passed = 0;
  int total  = 0;

  uart_rx_frame_buffer #(
    .DATA_SIZE      (DATA_SIZE),
    .DEPTH          (DEPTH),
    .SYNC_STAGES    (2),
    .CNT_WIDTH      (CNT_WIDTH),
    .TIMEOUT_CYCLES (16'd100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done      (rx_done),
    .rx_data      (rx_data),
    .parity_error (parity_error),
    .stop_error   (stop_error),
    .break_error  (break_error),
    .clear        (clear),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_err       (rd_err),
    .level        (level),
    .full         (full),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .err_count    (err_count)
`ifdef UART_RX_TIMEOUT_EN
    ,
    .rx_timeout   (rx_timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [2:0] tags, input int hold);
    rx_data = d;
    {break_error, stop_error, parity_error} = tags;
    rx_done = 1'b1;
    repeat (hold) tick();
    rx_done = 1'b0;
    {break_error, stop_error, parity_error} = 3'b000;
    repeat (6) tick();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++; if ({rd_valid, full, overflow} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {rd_valid, full, overflow}); else passed++;
    total++; if (level !== '0) $display("FAIL reset_level got=%0d exp=0", level); else passed++;
    total++; if ({rd_data, rd_err} !== 11'd0) $display("FAIL reset_head got=%h exp=0", {rd_data, rd_err}); else passed++;
    total++; if ({drop_count, err_count} !== 16'd0) $display("FAIL reset_counts got=%h exp=0", {drop_count, err_count}); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    rx_data = 8'hA5;
    rx_done = 1'b1;
    repeat (3) tick();
    total++; if (rd_valid !== 1'b0) $display("FAIL single_early_valid got=%b exp=0", rd_valid); else passed++;
    tick();
    total++; if (rd_valid !== 1'b1) $display("FAIL single_valid_latency got=%b exp=1", rd_valid); else passed++;
    total++; if (rd_data !== 8'hA5) $display("FAIL single_data got=%h exp=a5", rd_data); else passed++;
    total++; if (rd_err !== 3'b000) $display("FAIL single_err got=%b exp=000", rd_err); else passed++;
    repeat (36) tick();
    rx_done = 1'b0;
    repeat (6) tick();
    total++; if (level !== 3'd1) $display("FAIL single_level got=%0d exp=1", level); else passed++;
    pop_one();
    total++; if (level !== 3'd0 || rd_valid !== 1'b0) $display("FAIL single_pop got=%0d/%b exp=0/0", level, rd_valid); else passed++;
  endtask

  task automatic test_error_tags();
    logic [7:0] exp_d [3];
    logic [2:0] exp_e [3];
    exp_d[0] = 8'h11; exp_e[0] = 3'b001;
    exp_d[1] = 8'h22; exp_e[1] = 3'b010;
    exp_d[2] = 8'h33; exp_e[2] = 3'b100;
    pulse_clear();
    for (int i = 0; i < 3; i++) send_frame(exp_d[i], exp_e[i], 8);
    total++; if (err_count !== 8'd3) $display("FAIL tags_err_count got=%0d exp=3", err_count); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if ({rd_data, rd_err} !== {exp_d[i], exp_e[i]}) $display("FAIL tags_entry%0d got=%h/%b exp=%h/%b", i, rd_data, rd_err, exp_d[i], exp_e[i]); else passed++;
      pop_one();
    end
  endtask

  task automatic test_overflow();
    pulse_clear();
    for (int i = 1; i <= 6; i++) send_frame(8'(i), 3'b000, 8);
    total++; if (full !== 1'b1 || level !== 3'd4) $display("FAIL ovf_full got=%b/%0d exp=1/4", full, level); else passed++;
    total++; if (drop_count !== 8'd2) $display("FAIL ovf_drop_count got=%0d exp=2", drop_count); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", overflow); else passed++;
    for (int i = 1; i <= 4; i++) begin
      total++; if (rd_data !== 8'(i)) $display("FAIL ovf_entry%0d got=%h exp=%h", i, rd_data, 8'(i)); else passed++;
      pop_one();
    end
    total++; if (rd_valid !== 1'b0 || overflow !== 1'b1) $display("FAIL ovf_drained got=%b/%b exp=0/1", rd_valid, overflow); else passed++;
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_q [$];
    pulse_clear();
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h40 + 8'(i), 3'b000, 8);
      exp_q.push_back(8'h40 + 8'(i));
    end
    for (int k = 4; k < 10; k++) begin
      rx_data = 8'h40 + 8'(k);
      rx_done = 1'b1;
      repeat (3) tick();
      total++; if (rd_data !== exp_q[0]) $display("FAIL fullpop_head%0d got=%h exp=%h", k, rd_data, exp_q[0]); else passed++;
      pop_one();
      void'(exp_q.pop_front());
      exp_q.push_back(8'h40 + 8'(k));
      total++; if (level !== 3'd4 || drop_count !== 8'd0) $display("FAIL fullpop_level%0d got=%0d/%0d exp=4/0", k, level, drop_count); else passed++;
      repeat (4) tick();
      rx_done = 1'b0;
      repeat (6) tick();
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (rd_data !== exp_q[i]) $display("FAIL fullpop_drain%0d got=%h exp=%h", i, rd_data, exp_q[i]); else passed++;
      pop_one();
    end
    total++; if (rd_valid !== 1'b0 || overflow !== 1'b0) $display("FAIL fullpop_end got=%b/%b exp=0/0", rd_valid, overflow); else passed++;
  endtask

  task automatic test_clear();
    pulse_clear();
    for (int i = 0; i < 3; i++) send_frame(8'h70 + 8'(i), 3'b001, 8);
    total++; if (level !== 3'd3 || err_count !== 8'd3) $display("FAIL clear_before got=%0d/%0d exp=3/3", level, err_count); else passed++;
    pulse_clear();
    total++; if (level !== 3'd0 || rd_valid !== 1'b0) $display("FAIL clear_empty got=%0d/%b exp=0/0", level, rd_valid); else passed++;
    total++; if ({err_count, drop_count, overflow} !== 17'd0) $display("FAIL clear_counts got=%h exp=0", {err_count, drop_count, overflow}); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    rx_data = 8'h5C;
    rx_done = 1'b1;
    repeat (6) tick();
    total++; if (level !== 3'd1) $display("FAIL rst_mid_pre got=%0d exp=1", level); else passed++;
    reset = 1'b1;
    #1;
    total++; if (level !== 3'd0 || rd_valid !== 1'b0) $display("FAIL rst_mid_async got=%0d/%b exp=0/0", level, rd_valid); else passed++;
    repeat (2) tick();
    reset = 1'b0;
    repeat (6) tick();
    total++; if (level !== 3'd1 || rd_data !== 8'h5C) $display("FAIL rst_mid_recapture got=%0d/%h exp=1/5c", level, rd_data); else passed++;
    rx_done = 1'b0;
    repeat (6) tick();
    total++; if (level !== 3'd1) $display("FAIL rst_mid_once got=%0d exp=1", level); else passed++;
    pop_one();
  endtask

`ifdef UART_RX_TIMEOUT_EN
  task automatic test_timeout();
    pulse_clear();
    rx_data = 8'h99;
    rx_done = 1'b1;
    repeat (4) tick();
    repeat (99) tick();
    total++; if (rx_timeout !== 1'b0) $display("FAIL timeout_early got=%b exp=0", rx_timeout); else passed++;
    tick();
    total++; if (rx_timeout !== 1'b1) $display("FAIL timeout_assert got=%b exp=1", rx_timeout); else passed++;
    rx_done = 1'b0;
    repeat (6) tick();
    total++; if (rx_timeout !== 1'b1) $display("FAIL timeout_hold got=%b exp=1", rx_timeout); else passed++;
    pop_one();
    total++; if (rx_timeout !== 1'b0) $display("FAIL timeout_pop got=%b exp=0", rx_timeout); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_error_tags();
    test_overflow();
    test_full_pop();
    test_clear();
    test_reset_mid_frame();
`ifdef UART_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_buffer.md
Name: uart_rx_frame_buffer

Overview:
Receive-side capture buffer for the UART subsystem, running in the system clock domain. It sits between uart_receiver and the bus.
- Synchronises the receiver's level-type rx_done.
- Captures one frame per rx_done assertion, tagged with its parity, stop and break error flags.
- Stores frames in a parametrised first-word-fall-through FIFO.
- Reports level, overflow and error statistics.
It replaces the ad-hoc rx_done edge-capture FSM plus the fixed 8-deep FIFO.

Parameters:
DATA_SIZE, 8, payload width of one UART frame (5..9)
DEPTH, 16, FIFO entries; power of two, >= 2
SYNC_STAGES, 2, flops in the rx_done synchroniser (>= 2)
CNT_WIDTH, 8, width of the saturating drop and error counters
TIMEOUT_CYCLES, 16'd4000, idle clk cycles before rx_timeout asserts (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
rx_done  in  1  level from uart_receiver; high for >= SYNC_STAGES+2 clk cycles per frame
rx_data  in  DATA_SIZE  frame payload; stable while rx_done is high
parity_error  in  1  frame tag; stable while rx_done is high
stop_error  in  1  frame tag; stable while rx_done is high
break_error  in  1  frame tag; stable while rx_done is high
clear  in  1  synchronous flush of the FIFO, counters and sticky flags
rd_ready  in  1  consumer pops the head entry when rd_valid is also high
rd_valid  out  1  FIFO non-empty
rd_data  out  DATA_SIZE  head-entry payload
rd_err  out  3  head-entry tags {break, stop, parity}
level  out  $clog2(DEPTH+1)  current occupancy
full  out  1  level == DEPTH
overflow  out  1  sticky; set when a frame is dropped
drop_count  out  CNT_WIDTH  saturating count of dropped frames
err_count  out  CNT_WIDTH  saturating count of accepted frames with any tag set

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - All outputs 0; FIFO empty.
  - FSM in IDLE.
  - Synchroniser flops 0.
- Synchroniser: rx_done passes through SYNC_STAGES flops to give done_s. Data and tag inputs are not synchronised; their stability while rx_done is high makes this safe.
- Capture FSM, two one-hot states:
  - IDLE: when done_s == 1, issue a push (one cycle) and go to WAIT_LOW.
  - WAIT_LOW: no push. When done_s == 0, go to IDLE.
  - Result: exactly one push per rx_done assertion, however long it is held.
- Latency:
  - rx_done rising -> push strobe in cycle SYNC_STAGES+1.
  - If the FIFO was empty, rd_valid/rd_data are valid in the next cycle.
- Push and pop rules:
  - Pop occurs when rd_valid & rd_ready.
  - Pop while empty is ignored.
  - Push while not full is stored as {break, stop, parity, data}.
  - Push while full with a pop in the same cycle: accepted; level unchanged.
  - Push while full with no pop: frame dropped; overflow <= 1; drop_count increments, saturating at all-ones.
  - Simultaneous push and pop on an empty FIFO: push is stored and the pop is ignored (rd_valid was 0).
- Pointers: log2(DEPTH) bits, wrap naturally. level is a separate counter: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- err_count increments, saturating, on each accepted push whose tags are non-zero. Dropped frames do not count.
- clear:
  - Next cycle: FIFO is empty and counters, overflow and rx_timeout are 0.
  - clear has priority over any push or pop in the same cycle.
  - The FSM state is kept, so a frame that is mid-assertion is not re-captured.
- Reset mid-frame: the FSM returns to IDLE. If rx_done is still high after reset releases, that frame is captured once.

Optional Feature:
UART_RX_TIMEOUT_EN
- Defined:
  - Adds output rx_timeout (1 bit) and a 16-bit idle counter.
  - The counter resets on every push, pop or clear and counts while the FIFO is non-empty.
  - rx_timeout asserts when the count reaches TIMEOUT_CYCLES. It stays high until the next push, pop, clear or reset.
- Undefined: no port, no counter, and TIMEOUT_CYCLES is unused.

Decomposition:
- Package uart_pkg holds:
  - typedef uart_err_t, a packed struct {break_e, stop_e, parity_e}.
  - The capture FSM state enum (IDLE = 2'b01, WAIT_LOW = 2'b10).
  - A saturating-increment function.
- Sub-module uart_tag_fifo: generic FWFT FIFO (WIDTH, DEPTH) with push, pop, full, empty and level outputs. It is instantiated once with WIDTH = DATA_SIZE+3.

Test Plan:
- Single frame: rx_done high 40 cycles, rx_data=8'hA5, no tags -> one entry; rd_valid at cycle SYNC_STAGES+2 after the rise; rd_data=8'hA5, rd_err=3'b000; level=1; pop -> level 0.
- Error tagging: frames 8'h11 with parity_error, 8'h22 with stop_error, 8'h33 with break_error -> rd_err sequence 3'b001, 3'b010, 3'b100; err_count=3.
- Overflow with DEPTH=4 and rd_ready=0: send frames 1..6 -> full=1, level=4; entries are 1..4; drop_count=2; overflow=1. Then pop all -> rd_valid=0; overflow stays 1.
- Full with same-cycle pop: DEPTH=4 full; rd_ready=1 in the push cycle -> frame accepted, level stays 4, drop_count stays 0. Wrap-around order verified over 10 frames.
- Clear and reset: with 3 entries, pulse clear -> next cycle level=0 and counters 0. Assert reset while rx_done is high -> outputs 0; after release exactly one capture of the held frame.
- UART_RX_TIMEOUT_EN, TIMEOUT_CYCLES=100: one frame, no pop -> rx_timeout=1 exactly 100 cycles after the push; a pop drops it.
